// File: rtl/regs_pkg.sv
// Shared definitions for the RV32I integer register file: register addressing,
// data width and the write-back triple carried from the execute stage.
package regs_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_NUM_ISA = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   typedef struct packed {
      logic      wen;
      reg_addr_t addr;
      reg_data_t data;
   } wb_t;

   // A write only changes architectural state when it targets x1..x31.
   function automatic logic is_eff_write(input wb_t wb);
      return wb.wen && (wb.addr != ZERO_REG);
   endfunction

endpackage

// File: rtl/regs_if.sv
// Register file bus: write-back triple, two decode read ports, the debug read
// port and the retired-write counter.
interface regs_if
   import regs_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic             reg_wen_i;
   reg_addr_t        rd_addr_i;
   reg_data_t        rd_data_i;
   reg_addr_t        reg1_raddr_i;
   reg_addr_t        reg2_raddr_i;
   reg_data_t        reg1_rdata_o;
   reg_data_t        reg2_rdata_o;
   reg_addr_t        dbg_raddr_i;
   reg_data_t        dbg_rdata_o;
   logic [CNT_W-1:0] wr_cnt_o;

   modport master (
      output reg_wen_i, rd_addr_i, rd_data_i,
      output reg1_raddr_i, reg2_raddr_i, dbg_raddr_i,
      input  reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
   );

   modport slave (
      input  reg_wen_i, rd_addr_i, rd_data_i,
      input  reg1_raddr_i, reg2_raddr_i, dbg_raddr_i,
      output reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
   );

endinterface

// File: rtl/regs_rd_port.sv
// One register-file read port: x0 forces zero, then same-cycle write bypass,
// then the stored value.
module regs_rd_port
   import regs_pkg::*;
#(
   parameter int REG_NUM = 32
) (
   input  reg_addr_t                        raddr,
   input  logic [REG_NUM-1:1][REG_DATA_W-1:0] storage,
   input  wb_t                              wb,
   output reg_data_t                        rdata
);

   always_comb begin
      rdata = '0;
      if (raddr == ZERO_REG) begin
         rdata = '0;
      end else if (is_eff_write(wb) && (wb.addr == raddr)) begin
         rdata = wb.data;
      end else begin
         rdata = storage[raddr];
      end
   end

endmodule

// File: rtl/regs.sv
// RV32I integer register file: 31 writable registers (x0 hardwired to zero),
// combinational bypassed reads, registered debug read and retired-write counter.
module regs
   import regs_pkg::*;
#(
   parameter int REG_NUM = REG_NUM_ISA,
   parameter int CNT_W   = 32
) (
   input logic  clk,
   input logic  rst,
   regs_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [REG_NUM-1:1][REG_DATA_W-1:0] storage_q;
   logic [CNT_W-1:0]                   wr_cnt_q;
   reg_data_t                          dbg_rdata_q;
   reg_data_t                          dbg_rdata_d;
   reg_data_t                          reg1_rdata;
   reg_data_t                          reg2_rdata;
   wb_t                                wb;

   assign wb.wen  = bus.reg_wen_i;
   assign wb.addr = bus.rd_addr_i;
   assign wb.data = bus.rd_data_i;

   regs_rd_port #(.REG_NUM(REG_NUM)) u_rd_port1 (
      .raddr   (bus.reg1_raddr_i),
      .storage (storage_q),
      .wb      (wb),
      .rdata   (reg1_rdata)
   );

   regs_rd_port #(.REG_NUM(REG_NUM)) u_rd_port2 (
      .raddr   (bus.reg2_raddr_i),
      .storage (storage_q),
      .wb      (wb),
      .rdata   (reg2_rdata)
   );

   regs_rd_port #(.REG_NUM(REG_NUM)) u_rd_port_dbg (
      .raddr   (bus.dbg_raddr_i),
      .storage (storage_q),
      .wb      (wb),
      .rdata   (dbg_rdata_d)
   );

   // Reset wins over a write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < REG_NUM; i++) begin
            storage_q[i] <= '0;
         end
         wr_cnt_q    <= '0;
         dbg_rdata_q <= '0;
      end else begin
         if (is_eff_write(wb)) begin
            storage_q[wb.addr] <= wb.data;
            wr_cnt_q           <= wr_cnt_q + CNT_ONE;
         end
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign bus.reg1_rdata_o = reg1_rdata;
   assign bus.reg2_rdata_o = reg2_rdata;
   assign bus.dbg_rdata_o  = dbg_rdata_q;
   assign bus.wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_regs.sv
// Directed self-checking bench for the regs register file (counter width 5
// so that wrap-around is reachable).
module tb_regs;
  import regs_pkg::*;

  localparam int CNT_W = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regs_if #(.CNT_W(CNT_W)) bus ();

  regs #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.reg_wen_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.reg1_raddr_i = 5'(a);
      bus.reg2_raddr_i = 5'(31 - a);
      #1;
      checks++;
      if (bus.reg1_rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1 addr %0d got %h want 0", a, bus.reg1_rdata_o);
      end
      checks++;
      if (bus.reg2_rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 addr %0d got %h want 0", 31 - a, bus.reg2_rdata_o);
      end
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", bus.wr_cnt_o);
    end
    checks++;
    if (bus.dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_dbg got %h want 0", bus.dbg_rdata_o);
    end
  endtask

  task automatic test_write_read();
    bus.reg_wen_i = 1'b1;
    bus.rd_addr_i = 5'd5;
    bus.rd_data_i = 32'hDEADBEEF;
    cycle();
    bus.reg_wen_i    = 1'b0;
    bus.reg1_raddr_i = 5'd5;
    bus.reg2_raddr_i = 5'd5;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd1 got %h want deadbeef", bus.reg1_rdata_o);
    end
    checks++;
    if (bus.reg2_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd2 got %h want deadbeef", bus.reg2_rdata_o);
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd1) begin
      errors++;
      $display("FAIL wr_cnt got %0d want 1", bus.wr_cnt_o);
    end
  endtask

  task automatic test_bypass();
    bus.reg_wen_i    = 1'b1;
    bus.rd_addr_i    = 5'd7;
    bus.rd_data_i    = 32'h12345678;
    bus.reg1_raddr_i = 5'd7;
    bus.reg2_raddr_i = 5'd5;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_rd1 got %h want 12345678", bus.reg1_rdata_o);
    end
    checks++;
    if (bus.reg2_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_rd2_other got %h want deadbeef", bus.reg2_rdata_o);
    end
    cycle();
    bus.reg_wen_i    = 1'b0;
    bus.rd_data_i    = 32'h0;
    bus.reg2_raddr_i = 5'd7;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_stored1 got %h want 12345678", bus.reg1_rdata_o);
    end
    checks++;
    if (bus.reg2_rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_stored2 got %h want 12345678", bus.reg2_rdata_o);
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd2) begin
      errors++;
      $display("FAIL bypass_cnt got %0d want 2", bus.wr_cnt_o);
    end
  endtask

  task automatic test_x0();
    bus.reg_wen_i    = 1'b1;
    bus.rd_addr_i    = 5'd0;
    bus.rd_data_i    = 32'hFFFFFFFF;
    bus.reg1_raddr_i = 5'd0;
    bus.reg2_raddr_i = 5'd0;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h0 || bus.reg2_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL x0_same got %h %h want 0 0", bus.reg1_rdata_o, bus.reg2_rdata_o);
    end
    cycle();
    bus.reg_wen_i = 1'b0;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h0 || bus.reg2_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL x0_next got %h %h want 0 0", bus.reg1_rdata_o, bus.reg2_rdata_o);
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd2) begin
      errors++;
      $display("FAIL x0_cnt got %0d want 2", bus.wr_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.reg_wen_i = 1'b1;
    bus.rd_addr_i = 5'd10;
    bus.rd_data_i = 32'h1;
    bus.dbg_raddr_i = 5'd5;
    cycle();
    rst = 1'b1;
    bus.rd_addr_i    = 5'd11;
    bus.rd_data_i    = 32'h2;
    bus.reg1_raddr_i = 5'd11;
    bus.reg2_raddr_i = 5'd10;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h2) begin
      errors++;
      $display("FAIL rstmid_bypass got %h want 2", bus.reg1_rdata_o);
    end
    checks++;
    if (bus.dbg_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rstmid_dbg_pre got %h want deadbeef", bus.dbg_rdata_o);
    end
    cycle();
    rst = 1'b0;
    bus.reg_wen_i = 1'b0;
    bus.reg1_raddr_i = 5'd10;
    bus.reg2_raddr_i = 5'd11;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'h0 || bus.reg2_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_regs got %h %h want 0 0", bus.reg1_rdata_o, bus.reg2_rdata_o);
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd0 || bus.dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_cnt_dbg got %0d %h want 0 0", bus.wr_cnt_o, bus.dbg_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addr;
    logic [31:0] data;
    bus.dbg_raddr_i = 5'd0;
    for (int k = 0; k < 33; k++) begin
      addr = (k < 31) ? 5'(k + 1) : 5'(k - 30);
      data = 32'hC0DE0000 | 32'(k);
      bus.reg_wen_i = 1'b1;
      bus.rd_addr_i = addr;
      bus.rd_data_i = data;
      cycle();
      checks++;
      if (bus.wr_cnt_o !== 5'((k + 1) % 32)) begin
        errors++;
        $display("FAIL b2b_cnt write %0d got %0d want %0d", k, bus.wr_cnt_o, (k + 1) % 32);
      end
    end
    bus.reg_wen_i    = 1'b0;
    bus.reg1_raddr_i = 5'd1;
    bus.reg2_raddr_i = 5'd2;
    bus.dbg_raddr_i  = 5'd31;
    #1;
    checks++;
    if (bus.reg1_rdata_o !== 32'hC0DE001F || bus.reg2_rdata_o !== 32'hC0DE0020) begin
      errors++;
      $display("FAIL b2b_overwrite got %h %h want c0de001f c0de0020", bus.reg1_rdata_o,
               bus.reg2_rdata_o);
    end
    checks++;
    if (bus.dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL dbg_latency got %h want 0", bus.dbg_rdata_o);
    end
    cycle();
    checks++;
    if (bus.dbg_rdata_o !== 32'hC0DE001E) begin
      errors++;
      $display("FAIL dbg_x31 got %h want c0de001e", bus.dbg_rdata_o);
    end
    bus.reg_wen_i   = 1'b1;
    bus.rd_addr_i   = 5'd3;
    bus.rd_data_i   = 32'h00000055;
    bus.dbg_raddr_i = 5'd3;
    cycle();
    bus.reg_wen_i = 1'b0;
    checks++;
    if (bus.dbg_rdata_o !== 32'h00000055) begin
      errors++;
      $display("FAIL dbg_bypass got %h want 00000055", bus.dbg_rdata_o);
    end
    checks++;
    if (bus.wr_cnt_o !== 5'd2) begin
      errors++;
      $display("FAIL b2b_final_cnt got %0d want 2", bus.wr_cnt_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.reg_wen_i    = 1'b0;
    bus.rd_addr_i    = 5'd0;
    bus.rd_data_i    = 32'h0;
    bus.reg1_raddr_i = 5'd0;
    bus.reg2_raddr_i = 5'd0;
    bus.dbg_raddr_i  = 5'd0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
